// File: rtl/fp_normalize_pack.sv
// -----------------------------------------------------------------------------
// fp_normalize_pack
//   Back end of the single-precision FP adder. It takes the raw mantissa sum
//   from the previous stage and normalises it. A carry-out causes one right
//   shift at capture time. A missing hidden bit causes one left shift per
//   cycle in SHIFT. The block then adjusts the biased exponent and packs the
//   IEEE-754 word {sign, exponent, fraction}.
//   Zero, overflow (to infinity) and underflow (flush to zero) are flagged.
//   Only one operation is in flight at a time, with valid/ready on both sides.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   in_valid       operation on sign_in/exp_in/sum_in is valid
//   in_ready       block is idle and can capture an operation
//   sign_in        result sign
//   exp_in         biased exponent of the larger operand
//   sum_in         {carry, hidden, fraction} raw mantissa sum
//   out_valid      result_out and flags are valid
//   out_ready      downstream accepts the result
//   result_out     packed IEEE-754 result
//   zero_out       exact-zero result
//   overflow_out   result saturated to +/-infinity
//   underflow_out  result flushed to signed zero
// -----------------------------------------------------------------------------
module fp_normalize_pack #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sign_in,
  input  logic [EXPO_WIDTH-1:0] exp_in,
  input  logic [MENT_WIDTH+1:0] sum_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  zero_out,
  output logic                  overflow_out,
  output logic                  underflow_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Exponent is carried with one extra bit so an increment cannot wrap.
  localparam logic [EXPO_WIDTH:0] EXP_ONE = {{EXPO_WIDTH{1'b0}}, 1'b1};
  localparam logic [EXPO_WIDTH:0] EXP_MAX = {1'b0, {EXPO_WIDTH{1'b1}}};

  state_e                state_q;
  logic                  in_ready_q;
  logic                  sign_q;
  logic [MENT_WIDTH:0]   mant_q;
  logic [EXPO_WIDTH:0]   exp_q;
  // Result computed on entry to DONE, published one cycle later with out_valid.
  logic [DATA_WIDTH-1:0] pend_res_q;
  logic                  pend_zero_q;
  logic                  pend_ovf_q;
  logic                  pend_unf_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  ovf_q;
  logic                  unf_q;

  // Capture-time decode
  logic [EXPO_WIDTH:0]   exp_ext_s;
  logic [EXPO_WIDTH:0]   exp_inc_s;
  logic                  cap_fast_s;
  logic [DATA_WIDTH-1:0] cap_res_s;
  logic                  cap_zero_s;
  logic                  cap_ovf_s;
  logic                  cap_unf_s;
  logic [MENT_WIDTH:0]   cap_mant_s;
  logic [EXPO_WIDTH:0]   cap_exp_s;

  function automatic logic [DATA_WIDTH-1:0] pack_inf(input logic s);
    return {s, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pack_zero(input logic s);
    return {s, {(DATA_WIDTH-1){1'b0}}};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pack_norm(input logic s,
                                                      input logic [EXPO_WIDTH:0] e,
                                                      input logic [MENT_WIDTH:0] m);
    return {s, e[EXPO_WIDTH-1:0], m[MENT_WIDTH-1:0]};
  endfunction

  // Classify the incoming operation; the checks run in priority order.
  always_comb begin
    exp_ext_s  = {1'b0, exp_in};
    exp_inc_s  = exp_ext_s + EXP_ONE;
    cap_fast_s = 1'b0;
    cap_res_s  = {DATA_WIDTH{1'b0}};
    cap_zero_s = 1'b0;
    cap_ovf_s  = 1'b0;
    cap_unf_s  = 1'b0;
    cap_mant_s = sum_in[MENT_WIDTH:0];
    cap_exp_s  = exp_ext_s;
    if (sum_in == {(MENT_WIDTH+2){1'b0}}) begin
      // Exact zero is always +0 whatever sign_in says.
      cap_fast_s = 1'b1;
      cap_zero_s = 1'b1;
    end else if (exp_in == {EXPO_WIDTH{1'b0}}) begin
      // Denormals are not supported; treat as underflow.
      cap_fast_s = 1'b1;
      cap_res_s  = pack_zero(sign_in);
      cap_unf_s  = 1'b1;
    end else if (exp_in == {EXPO_WIDTH{1'b1}}) begin
      cap_fast_s = 1'b1;
      cap_res_s  = pack_inf(sign_in);
      cap_ovf_s  = 1'b1;
    end else if (sum_in[MENT_WIDTH+1]) begin
      // Carry-out: truncating right shift. The old carry becomes the hidden
      // bit, so SHIFT will complete on its first evaluation.
      cap_mant_s = sum_in[MENT_WIDTH+1:1];
      cap_exp_s  = exp_inc_s;
      if (exp_inc_s == EXP_MAX) begin
        cap_fast_s = 1'b1;
        cap_res_s  = pack_inf(sign_in);
        cap_ovf_s  = 1'b1;
      end else begin
        cap_fast_s = 1'b0;
      end
    end else begin
      cap_fast_s = 1'b0;
    end
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      sign_q      <= 1'b0;
      mant_q      <= {(MENT_WIDTH+1){1'b0}};
      exp_q       <= {(EXPO_WIDTH+1){1'b0}};
      pend_res_q  <= {DATA_WIDTH{1'b0}};
      pend_zero_q <= 1'b0;
      pend_ovf_q  <= 1'b0;
      pend_unf_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {DATA_WIDTH{1'b0}};
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q  <= 1'b0;
            sign_q      <= sign_in;
            mant_q      <= cap_mant_s;
            exp_q       <= cap_exp_s;
            pend_res_q  <= cap_res_s;
            pend_zero_q <= cap_zero_s;
            pend_ovf_q  <= cap_ovf_s;
            pend_unf_q  <= cap_unf_s;
            out_valid_q <= 1'b0;
            result_q    <= {DATA_WIDTH{1'b0}};
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            state_q     <= cap_fast_s ? DONE : SHIFT;
          end else begin
            in_ready_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (mant_q[MENT_WIDTH]) begin
            pend_res_q <= pack_norm(sign_q, exp_q, mant_q);
            state_q    <= DONE;
          end else if (exp_q == EXP_ONE) begin
            // Exponent would drop to the denormal range: flush to zero.
            pend_res_q <= pack_zero(sign_q);
            pend_unf_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            mant_q <= {mant_q[MENT_WIDTH-1:0], 1'b0};
            exp_q  <= exp_q - EXP_ONE;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= pend_res_q;
            zero_q      <= pend_zero_q;
            ovf_q       <= pend_ovf_q;
            unf_q       <= pend_unf_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            result_q    <= {DATA_WIDTH{1'b0}};
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            // Stalled: hold the result until downstream accepts it.
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          result_q    <= {DATA_WIDTH{1'b0}};
          zero_q      <= 1'b0;
          ovf_q       <= 1'b0;
          unf_q       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign result_out    = result_q;
  assign zero_out      = zero_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
module tb_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] sum_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_out;
  logic        zero_out;
  logic        overflow_out;
  logic        underflow_out;

  int checks = 0;
  int errors = 0;

  fp_normalize_pack #(.DATA_WIDTH(32), .MENT_WIDTH(23), .EXPO_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .sum_in(sum_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_out(result_out), .zero_out(zero_out),
    .overflow_out(overflow_out), .underflow_out(underflow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] sum;
    logic [31:0] res;
    logic [2:0]  flg;   // {zero, overflow, underflow}
    int          lat;   // edges after capture until out_valid is seen
    int          stall; // cycles out_ready stays low once out_valid is up
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: locate the leading one, derive shift count and final exponent.
  function automatic void model(input logic s, input int e, input int sm,
                                output logic [31:0] r, output logic [2:0] f,
                                output int lat);
    int v, ex, p, k;
    logic [31:0] mf;
    logic [7:0]  eo;
    r = 32'h0; f = 3'b000; lat = 1;
    if (sm == 0) begin
      f = 3'b100;
    end else if (e == 0) begin
      r = {s, 31'h0}; f = 3'b001;
    end else if (e == 255) begin
      r = {s, 8'hFF, 23'h0}; f = 3'b010;
    end else begin
      v = sm; ex = e; lat = 2;
      if (v >= (1 << 24)) begin
        v = v / 2; ex = ex + 1;
      end
      if (ex == 255) begin
        r = {s, 8'hFF, 23'h0}; f = 3'b010; lat = 1;
      end else begin
        p = 0;
        for (int i = 0; i < 24; i++) if (((v >> i) & 1) == 1) p = i;
        k = 23 - p;
        if (k > ex - 1) begin
          r = {s, 31'h0}; f = 3'b001; lat = ex + 1;
        end else begin
          mf = 32'(v << k);
          eo = 8'(ex - k);
          r = {s, eo, mf[22:0]};
          lat = k + 2;
        end
      end
    end
  endfunction

  task automatic run_op(input string nm, input logic s, input logic [7:0] e,
                        input logic [24:0] sm, input int stall,
                        input logic [31:0] r_exp, input logic [2:0] f_exp,
                        input int lat_exp);
    int n;
    logic [31:0] r0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " in_ready_before"}, {31'h0, in_ready}, 32'h1);
    sign_in = s; exp_in = e; sum_in = sm; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sum_in = 25'($urandom);
    exp_in = 8'($urandom);
    chk({nm, " in_ready_busy"}, {31'h0, in_ready}, 32'h0);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(lat_exp));
    chk({nm, " result"}, result_out, r_exp);
    chk({nm, " flags"}, {29'h0, zero_out, overflow_out, underflow_out}, {29'h0, f_exp});
    r0 = result_out;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({nm, " stall_result"}, result_out, r0);
      chk({nm, " stall_valid_ready"}, {30'h0, out_valid, in_ready}, 32'h2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, " post_hs"}, {27'h0, out_valid, in_ready, zero_out, overflow_out, underflow_out}, 32'h08);
    chk({nm, " post_hs_result"}, result_out, 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  f;
    int          lat, sel, msb, ev, sv;
    logic        s;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign_in = 1'b0; exp_in = 8'h0; sum_in = 25'h0;

    tbl[0]  = '{1'b0, 8'h7F, 25'h1800000, 32'h40400000, 3'b000, 2, 3};
    tbl[1]  = '{1'b0, 8'h80, 25'h0800000, 32'h40000000, 3'b000, 2, 0};
    tbl[2]  = '{1'b0, 8'h7F, 25'h0000001, 32'h34000000, 3'b000, 25, 0};
    tbl[3]  = '{1'b1, 8'h55, 25'h0000000, 32'h00000000, 3'b100, 1, 0};
    tbl[4]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b010, 1, 0};
    tbl[5]  = '{1'b1, 8'h02, 25'h0000100, 32'h80000000, 3'b001, 3, 0};
    tbl[6]  = '{1'b0, 8'h00, 25'h0123456, 32'h00000000, 3'b001, 1, 0};
    tbl[7]  = '{1'b1, 8'hFF, 25'h0800000, 32'hFF800000, 3'b010, 1, 1};
    tbl[8]  = '{1'b1, 8'h01, 25'h0400000, 32'h80000000, 3'b001, 2, 0};
    tbl[9]  = '{1'b0, 8'h01, 25'h0800000, 32'h00800000, 3'b000, 2, 0};
    tbl[10] = '{1'b1, 8'hFD, 25'h1FFFFFF, 32'hFF7FFFFF, 3'b000, 2, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'h0, in_ready}, 32'h0);
    chk("reset_outputs", {28'h0, out_valid, zero_out, overflow_out, underflow_out}, 32'h0);
    chk("reset_result", result_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {31'h0, in_ready}, 32'h1);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].e, tbl[i].sum, tbl[i].stall,
             tbl[i].res, tbl[i].flg, tbl[i].lat);
    end

    // Reset in the middle of a long normalisation
    @(negedge clk);
    sign_in = 1'b0; exp_in = 8'h7F; sum_in = 25'h0000001; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midshift_rst_flags", {28'h0, out_valid, zero_out, overflow_out, underflow_out}, 32'h0);
    chk("midshift_rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("midshift_rst_result", result_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    chk("midshift_discarded", 32'(lat), 32'h0);
    chk("midshift_recover_ready", {31'h0, in_ready}, 32'h1);

    // Randomised operations against the reference model
    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      case (sel)
        0:       ev = 0;
        1:       ev = 255;
        2:       ev = $urandom_range(1, 3);
        3:       ev = $urandom_range(250, 254);
        default: ev = $urandom_range(1, 254);
      endcase
      if ($urandom_range(0, 15) == 0) begin
        sv = 0;
      end else begin
        msb = $urandom_range(0, 24);
        sv = (1 << msb) | (int'($urandom) & ((1 << msb) - 1));
      end
      model(s, ev, sv, r, f, lat);
      run_op($sformatf("rnd%0d", i), s, 8'(ev), 25'(sv), $urandom_range(0, 2), r, f, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
